asymfifo_pop_drain: RTL and testbench

//  Pop-side consumer for the 24->8 asymmetric dual-clock FIFO; lives in the clk_pop domain.

---
 rtl/asymfifo_pkg.sv | 13 +
 rtl/asymfifo_pop_drain_skid.sv | 67 ++++++
 rtl/asymfifo_pop_drain.sv | 110 +++++++++++
 tb/tb_asymfifo_pop_drain.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/asymfifo_pkg.sv
// Shared definitions for the asymmetric-FIFO pop-side drain logic.
//   DATA_WIDTH_DEF : default stream/FIFO byte width
//   skid_entry_t   : one skid-buffer slot, a byte plus its group-end marker
package asymfifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] data;
    logic                      last;
  } skid_entry_t;

endpackage

// File: rtl/asymfifo_pop_drain_skid.sv
// skid_buf2: two-entry FIFO used as the skid buffer behind the FIFO pop port.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears entries and pointers)
//   wr_en     : write wr_data into the tail slot (caller guarantees occ < 2)
//   wr_data   : entry to store
//   rd_en     : retire the head slot (caller guarantees occ != 0)
//   rd_data   : head entry, straight from a register
//   occ       : number of occupied slots, 0..2
module skid_buf2
  import asymfifo_pkg::*;
#(
  parameter type entry_t = skid_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  entry_t     wr_data,
  input  logic       rd_en,
  output entry_t     rd_data,
  output logic [1:0] occ
);

  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] occ_reg;
  logic [1:0] occ_next;

  // Each slot is its own register so no storage element has two writers.
  // Slots are cleared on reset so the head reads as zero afterwards.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      entry_t entry_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (wr_en && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= wr_data;
        end
      end
    end
  endgenerate

  always_comb begin
    occ_next = occ_reg;
    case ({wr_en, rd_en})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;  // both or neither: occupancy unchanged
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
    end else begin
      if (wr_en) wr_ptr_reg <= ~wr_ptr_reg;
      if (rd_en) rd_ptr_reg <= ~rd_ptr_reg;
      occ_reg <= occ_next;
    end
  end

  assign rd_data = rd_ptr_reg ? g_slot[1].entry_reg : g_slot[0].entry_reg;
  assign occ     = occ_reg;

endmodule

// File: rtl/asymfifo_pop_drain.sv
// asymfifo_pop_drain: pop-side consumer of the 24->8 asymmetric FIFO (clk_pop domain).
// Pops bytes into a 2-entry skid buffer and re-emits them as a valid/ready stream,
// marking every PKT_LEN-th byte with m_last. Also keeps a sticky pop_error flag and a
// saturating popped-byte counter.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   enable              : allow pops (buffer keeps draining when low)
//   pop_empty/pop_error : FIFO status
//   data_out            : FIFO head byte
//   pop_req_n           : FIFO pop request, active-low
//   m_valid/m_ready     : stream handshake
//   m_data/m_last       : stream byte and group-end marker
//   err, err_clr        : sticky error flag and its clear (set wins)
//   byte_cnt            : total bytes popped, saturating
module asymfifo_pop_drain
  import asymfifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PKT_LEN    = 3,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  pop_empty,
  input  logic                  pop_error,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  pop_req_n,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  err,
  input  logic                  err_clr,
  output logic [CNT_WIDTH-1:0]  byte_cnt
);

  localparam int GW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [GW-1:0] GRP_MAX = GW'(PKT_LEN - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } entry_t;

  logic           pop;
  logic           xfer;
  logic [1:0]     occ;
  entry_t         wr_entry;
  entry_t         head;
  logic [GW-1:0]  grp_idx_reg;
  logic [GW-1:0]  grp_idx_next;
  logic           err_reg;
  logic [CNT_WIDTH-1:0] byte_cnt_reg;

  // Pop only from registered occupancy; a transfer in the same cycle does not open a
  // slot early, so there is no combinational path from m_ready to pop_req_n.
  assign pop       = enable & ~pop_empty & (occ != 2'd2) & ~rst;
  assign pop_req_n = ~pop;

  assign xfer = m_valid & m_ready;

  assign wr_entry.data = data_out;
  assign wr_entry.last = (grp_idx_reg == GRP_MAX);

  skid_buf2 #(
    .entry_t (entry_t)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pop),
    .wr_data (wr_entry),
    .rd_en   (xfer),
    .rd_data (head),
    .occ     (occ)
  );

  always_comb begin
    grp_idx_next = grp_idx_reg;
    if (pop) begin
      grp_idx_next = (grp_idx_reg == GRP_MAX) ? '0 : grp_idx_reg + 1'b1;
    end
  end

  // grp_idx only moves on pops, so pausing via enable keeps group alignment.
  always_ff @(posedge clk) begin
    if (rst) begin
      grp_idx_reg  <= '0;
      err_reg      <= 1'b0;
      byte_cnt_reg <= '0;
    end else begin
      grp_idx_reg <= grp_idx_next;
      if (pop_error) begin
        err_reg <= 1'b1;
      end else if (err_clr) begin
        err_reg <= 1'b0;
      end
      if (pop && (byte_cnt_reg != '1)) begin
        byte_cnt_reg <= byte_cnt_reg + 1'b1;
      end
    end
  end

  assign m_valid  = (occ != 2'd0);
  assign m_data   = head.data;
  assign m_last   = head.last;
  assign err      = err_reg;
  assign byte_cnt = byte_cnt_reg;

endmodule

// File: tb/tb_asymfifo_pop_drain.sv
module tb_asymfifo_pop_drain;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       pop_empty;
  logic       pop_error;
  logic [7:0] data_out;
  logic       pop_req_n;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       err;
  logic       err_clr;
  logic [3:0] byte_cnt;

  int checks   = 0;
  int failures = 0;

  // Behavioural source FIFO: the initial block appends, the pop request consumes.
  logic [7:0] fifo_mem [0:63];
  int         wr_idx = 0;
  int         rd_idx = 0;
  logic [8:0] exp_q [$];  // {last, data}

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!pop_req_n) rd_idx <= rd_idx + 1;
  end

  assign pop_empty = (rd_idx == wr_idx);
  assign data_out  = fifo_mem[rd_idx[5:0]];

  asymfifo_pop_drain #(
    .DATA_WIDTH (8),
    .PKT_LEN    (3),
    .CNT_WIDTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .pop_empty (pop_empty),
    .pop_error (pop_error),
    .data_out  (data_out),
    .pop_req_n (pop_req_n),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .err       (err),
    .err_clr   (err_clr),
    .byte_cnt  (byte_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d, input logic last, input bit expect_out);
    fifo_mem[wr_idx[5:0]] = d;
    wr_idx++;
    if (expect_out) exp_q.push_back({last, d});
  endtask

  // Raise m_ready and collect n transfers, comparing each against exp_q.
  task automatic drain(input string tag, input int n);
    int got;
    logic [8:0] e;
    got = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 4 * n + 10 && got < n; c++) begin
      if (m_valid && m_ready) begin
        e = exp_q.pop_front();
        chk({tag, "_data"}, {24'd0, m_data}, {24'd0, e[7:0]});
        chk({tag, "_last"}, {31'd0, m_last}, {31'd0, e[8]});
        $display("%s byte %0d data=%02h last=%0b cnt=%0d", tag, got, m_data, m_last, byte_cnt);
        got++;
      end
      tick(1);
    end
    chk({tag, "_count"}, got, n);
    chk({tag, "_idle"}, {31'd0, m_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; pop_error = 1'b0; err_clr = 1'b0; m_ready = 1'b0;
    tick(2);
    // Reset state
    chk("rst_pop_req_n", {31'd0, pop_req_n}, 32'd1);
    chk("rst_m_valid",   {31'd0, m_valid},   32'd0);
    chk("rst_m_data",    {24'd0, m_data},    32'd0);
    chk("rst_m_last",    {31'd0, m_last},    32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);
    chk("rst_byte_cnt",  {28'd0, byte_cnt},  32'd0);

    // 1: six bytes stream 1/clk, last on 3rd and 6th
    push(8'hA1, 1'b0, 1); push(8'hA2, 1'b0, 1); push(8'hA3, 1'b1, 1);
    push(8'hA4, 1'b0, 1); push(8'hA5, 1'b0, 1); push(8'hA6, 1'b1, 1);
    rst = 1'b0; enable = 1'b1; m_ready = 1'b1;
    tick(1);
    chk("t1_latency_valid", {31'd0, m_valid}, 32'd1);
    drain("t1", 6);
    chk("t1_byte_cnt", {28'd0, byte_cnt}, 32'd6);
    chk("t1_pop_req_n_empty", {31'd0, pop_req_n}, 32'd1);

    // 2: m_ready low -> exactly two pops, head held
    m_ready = 1'b0;
    push(8'hB1, 1'b0, 1); push(8'hB2, 1'b0, 1); push(8'hB3, 1'b1, 1);
    push(8'hB4, 1'b0, 1); push(8'hB5, 1'b0, 1);
    tick(3);
    chk("t2_pop_req_n_full", {31'd0, pop_req_n}, 32'd1);
    chk("t2_fifo_left", wr_idx - rd_idx, 32'd3);
    chk("t2_hold_data", {24'd0, m_data}, 32'hB1);
    tick(2);
    chk("t2_hold_data2", {24'd0, m_data}, 32'hB1);
    chk("t2_byte_cnt", {28'd0, byte_cnt}, 32'd8);
    drain("t2", 5);
    chk("t2_byte_cnt_end", {28'd0, byte_cnt}, 32'd11);

    // 3: pause after byte 2 of a group; resumed byte closes the group
    enable = 1'b0;
    push(8'hC1, 1'b1, 1); push(8'hC2, 1'b0, 1);
    tick(10);
    chk("t3_pause_pop_req_n", {31'd0, pop_req_n}, 32'd1);
    chk("t3_pause_valid", {31'd0, m_valid}, 32'd0);
    chk("t3_pause_left", wr_idx - rd_idx, 32'd2);
    enable = 1'b1;
    drain("t3", 2);
    chk("t3_byte_cnt", {28'd0, byte_cnt}, 32'd13);

    // 4: sticky error flag
    pop_error = 1'b1; tick(1); pop_error = 1'b0;
    chk("t4_err_set", {31'd0, err}, 32'd1);
    tick(1);
    chk("t4_err_sticky", {31'd0, err}, 32'd1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("t4_err_clr", {31'd0, err}, 32'd0);
    pop_error = 1'b1; err_clr = 1'b1; tick(1);
    pop_error = 1'b0; err_clr = 1'b0;
    chk("t4_err_set_wins", {31'd0, err}, 32'd1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("t4_err_clr2", {31'd0, err}, 32'd0);
    $display("t4 err sequence done err=%0b", err);

    // 5: reset with full buffer and mid-group index
    push(8'hD0, 1'b0, 1);
    drain("t5a", 1);
    m_ready = 1'b0;
    push(8'hD1, 1'b0, 0); push(8'hD2, 1'b0, 0);
    tick(3);
    chk("t5_full_valid", {31'd0, m_valid}, 32'd1);
    chk("t5_full_head", {24'd0, m_data}, 32'hD1);
    chk("t5_sat_cnt", {28'd0, byte_cnt}, 32'd15);
    rst = 1'b1; tick(1);
    chk("t5_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("t5_rst_cnt", {28'd0, byte_cnt}, 32'd0);
    chk("t5_rst_pop_req_n", {31'd0, pop_req_n}, 32'd1);
    chk("t5_rst_data", {24'd0, m_data}, 32'd0);
    rst = 1'b0;
    push(8'hE1, 1'b0, 1); push(8'hE2, 1'b0, 1); push(8'hE3, 1'b1, 1);
    drain("t5b", 3);
    chk("t5_cnt_after", {28'd0, byte_cnt}, 32'd3);

    // 6: 20 more bytes, counter saturates at 15
    for (int i = 0; i < 20; i++) push(8'(8'h40 + i), (i % 3) == 2, 1);
    drain("t6", 20);
    chk("t6_sat", {28'd0, byte_cnt}, 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
